decode_ctrl: RTL and testbench
==============================

# decode_ctrl

Handshake and sequencing controller for the decode stage. Sits between fetch and rename/dispatch and drives the combinational `decode` block. Accepts one instruction per cycle from fetch, applies the decoder's `nop`/`invalid` verdicts, and buffers resulting uops in a small FIFO so dispatch sees a registered, back-pressurable uop stream. Also owns the illegal-instruction trap state, pipeline flush, and two decode performance counters.

## Interface

**Parameters**
- `INSTR_WIDTH`, 32, instruction width.
- `ADDR_WIDTH`, 32, PC width.
- `QUEUE_DEPTH`, 2, uop FIFO entries; power of two, ≥2.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush.
- Fetch side:
  - `instr_in`  in  INSTR_WIDTH  instruction from fetch.
  - `instr_pc`  in  ADDR_WIDTH  PC of `instr_in`.
  - `instr_valid`  in  1  fetch offers an instruction.
  - `instr_ready`  out  1  controller accepts the instruction.
- Decoder side:
  - `dec_instr_out`  out  INSTR_WIDTH  to decoder `instr_in`; equals `instr_in` (combinational).
  - `dec_nop`  in  1  decoder `nop` flag.
  - `dec_invalid`  in  1  decoder `invalid` flag.
  - `dec_uop_in`  in  uop_t (UOP_WIDTH=60)  decoder `uop_out`.
- Dispatch side:
  - `uop_out`  out  uop_t  FIFO head uop.
  - `uop_pc`  out  ADDR_WIDTH  PC of head uop.
  - `uop_valid`  out  1  head valid.
  - `uop_ready`  in  1  dispatch consumes head.
- Trap and status:
  - `trap`  out  1  illegal-instruction trap pending.
  - `trap_pc`  out  ADDR_WIDTH  PC of the offending instruction.
  - `trap_instr`  out  INSTR_WIDTH  offending instruction word.
- Performance counters:
  - `perf_uop_count`  out  32  uops enqueued.
  - `perf_nop_count`  out  32  nops dropped.

## Operation

**FSM**
- `INIT` (reset state) → `RUN` unconditionally after one cycle.
- `RUN` → `TRAP` on an accepted instruction with `dec_invalid=1`.
- `TRAP` → `RUN` only on `flush`.
- `flush` in any non-INIT state → `RUN`.

**Accept rule**
- `instr_ready = (state==RUN) && (count<QUEUE_DEPTH) && !flush`.
- Depends only on registered state plus `flush`; there is no combinational path from `uop_ready`.
- Transfer happens when `instr_valid && instr_ready`.

**On transfer, by priority**
1. `dec_invalid`: no enqueue. Register `trap_pc`←`instr_pc` and `trap_instr`←`instr_in`. Next state `TRAP`.
2. `dec_nop`: drop; `perf_nop_count`+1.
3. Otherwise: enqueue `{dec_uop_in, instr_pc}` at the tail; `perf_uop_count`+1.

**Dequeue and FIFO**
- `uop_valid = (count!=0) && !flush`. A pop occurs when `uop_valid && uop_ready`.
- FIFO uses circular read/write pointers of width log2(QUEUE_DEPTH) that wrap naturally, plus a count 0..QUEUE_DEPTH.
- Simultaneous push and pop leave count unchanged. Push while full is impossible because `instr_ready` is low.

**TRAP state**
- `trap=1`; `instr_ready=0`.
- The FIFO keeps draining to dispatch.
- `trap_pc` and `trap_instr` hold until flush.

**Flush (synchronous, highest priority)**
- Empties the FIFO: pointers and count go to 0.
- State → `RUN`; `trap` → 0.
- No push and no pop in the flush cycle.
- Performance counters are not cleared.

**Counters**
- 32-bit; wrap from 0xFFFFFFFF to 0.

## Timing

**Reset values**
- State `INIT`; `instr_ready=0`; `uop_valid=0`; `uop_out=0`; `uop_pc=0`.
- `trap=0`; `trap_pc=0`; `trap_instr=0`; both counters 0.

**Startup**
- First `instr_ready=1` occurs in the second cycle after `rst` deasserts.

**Latency and throughput**
- Instruction accepted at edge N → `uop_valid` high after edge N (visible in cycle N+1). The uop is registered with no bypass.
- With `uop_ready` held 1, throughput is 1 uop/cycle: count stays at 1 under steady push+pop.
- With `uop_ready=0`, the controller accepts QUEUE_DEPTH instructions, then `instr_ready` drops.

**Trap and flush timing**
- `trap` rises in the cycle after the invalid instruction is accepted.
- `flush` takes effect at the next edge: the following cycle shows `uop_valid=0`, `trap=0`, and `instr_ready=1`.

**Asynchronous reset mid-operation**
- Immediately clears the FIFO, trap state, and counters; FSM goes to `INIT`.

## Test plan

1. **Reset and steady stream.** Release reset, then stream `addi x1,x0,1` (0x00100093) from PC 0x0 onward with `uop_ready=1`.
   - `instr_ready` is 0 for one cycle after reset.
   - One uop per cycle follows; `uop_pc` = 0x0, 0x4, 0x8, …
   - `perf_uop_count` equals the number of accepted instructions.
2. **Nop drop.** Send 0x00000013 (addi x0,x0,0) between two real adds.
   - Only 2 uops appear; `perf_nop_count`=1; the PCs of the real instructions are preserved.
3. **Backpressure.** Set `uop_ready=0` and offer 4 instructions.
   - Exactly QUEUE_DEPTH=2 are accepted, then `instr_ready=0`.
   - Raise `uop_ready`: the uops emerge in order with no loss or duplication.
4. **Illegal instruction.** Offer 0xFFFFFFFF at PC 0x100 with 1 older uop queued.
   - `trap=1`, `trap_pc=0x100`, `trap_instr=0xFFFFFFFF`.
   - The older uop still drains; `instr_ready` stays 0 until `flush`.
5. **Flush.** Assert `flush` with the FIFO full and `trap=1`.
   - Next cycle shows `uop_valid=0`, `trap=0`, `instr_ready=1`; counters unchanged.
6. **Counter wrap and async reset.** Force `perf_uop_count` to 0xFFFFFFFF and enqueue one uop → reads 0.
   - Assert `rst` mid-stream: all outputs return to reset values immediately.

Source files
------------

// File: rtl/decode_ctrl.sv
// decode_ctrl
//   Handshake and sequencing controller for the decode stage. Accepts one
//   instruction per cycle from fetch, forwards it to the combinational
//   decoder, applies the decoder's nop/invalid verdicts and buffers the
//   resulting uops in a small FIFO so dispatch sees a registered,
//   back-pressurable stream. Also owns the illegal-instruction trap state,
//   pipeline flush and two decode performance counters.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous pipeline flush (highest priority)
//   instr_in/pc     instruction and its PC from fetch
//   instr_valid     fetch offers an instruction
//   instr_ready     controller accepts it this cycle
//   dec_instr_out   instruction routed to the decoder (pass-through)
//   dec_nop         decoder says: architectural nop, drop it
//   dec_invalid     decoder says: illegal encoding, trap
//   dec_uop_in      decoded uop
//   uop_out/uop_pc  FIFO head uop and its PC
//   uop_valid       head is valid
//   uop_ready       dispatch consumes the head
//   trap            illegal-instruction trap pending
//   trap_pc/instr   PC and word of the offending instruction
//   perf_uop_count  uops enqueued (wraps)
//   perf_nop_count  nops dropped (wraps)
module decode_ctrl #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 2,
  parameter int UOP_WIDTH   = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] dec_instr_out,
  input  logic                   dec_nop,
  input  logic                   dec_invalid,
  input  logic [UOP_WIDTH-1:0]   dec_uop_in,
  output logic [UOP_WIDTH-1:0]   uop_out,
  output logic [ADDR_WIDTH-1:0]  uop_pc,
  output logic                   uop_valid,
  input  logic                   uop_ready,
  output logic                   trap,
  output logic [ADDR_WIDTH-1:0]  trap_pc,
  output logic [INSTR_WIDTH-1:0] trap_instr,
  output logic [31:0]            perf_uop_count,
  output logic [31:0]            perf_nop_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_TRAP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [UOP_WIDTH-1:0]  uop_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem  [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic [31:0] uop_cnt_q;
  logic [31:0] nop_cnt_q;

  logic accept;
  logic take_trap;
  logic drop_nop;
  logic push;
  logic pop;

  // The decoder is purely combinational and looks at the word fetch is
  // offering right now.
  assign dec_instr_out = instr_in;

  // Decoder verdicts are prioritised: invalid beats nop beats enqueue.
  assign accept    = instr_valid && instr_ready;
  assign take_trap = accept && dec_invalid;
  assign drop_nop  = accept && !dec_invalid && dec_nop;
  assign push      = accept && !dec_invalid && !dec_nop;
  assign pop       = uop_valid && uop_ready;

  assign uop_out        = uop_mem[rd_ptr];
  assign uop_pc         = pc_mem[rd_ptr];
  assign perf_uop_count = uop_cnt_q;
  assign perf_nop_count = nop_cnt_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. INIT always moves on after one cycle; once running,
  // flush is the only way out of TRAP and overrides a new trap.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_RUN;
        end else if (take_trap) begin
          state_nxt = ST_TRAP;
        end
      end
      ST_TRAP: begin
        if (flush) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Output logic. Both handshakes depend only on registered state and
  // flush, so there is no combinational path from uop_ready to
  // instr_ready; flush suppresses any transfer in its own cycle.
  always_comb begin
    instr_ready = 1'b0;
    uop_valid   = 1'b0;
    trap        = 1'b0;
    instr_ready = (state == ST_RUN) && (count < CNT_W'(QUEUE_DEPTH)) && !flush;
    uop_valid   = (count != '0) && !flush;
    trap        = (state == ST_TRAP);
  end

  // uop FIFO. Pointers wrap naturally because the depth is a power of two;
  // the separate count distinguishes full from empty. A push while full
  // cannot happen because instr_ready is low then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        uop_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        uop_mem[wr_ptr] <= dec_uop_in;
        pc_mem[wr_ptr]  <= instr_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Trap capture. The offending PC and word are held for software until
  // the next trap; the trap flag itself is cleared by flush via the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_pc    <= '0;
      trap_instr <= '0;
    end else if (take_trap) begin
      trap_pc    <= instr_pc;
      trap_instr <= instr_in;
    end
  end

  // Performance counters. They survive flush and wrap at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uop_cnt_q <= '0;
      nop_cnt_q <= '0;
    end else begin
      if (push) begin
        uop_cnt_q <= uop_cnt_q + 32'd1;
      end
      if (drop_nop) begin
        nop_cnt_q <= nop_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl
//   Testbench for decode_ctrl. A stand-in decoder flags 0x00000013 as nop
//   and 0xFFFFFFFF as invalid; everything else becomes a uop derived from
//   the instruction word. A queue-based reference model tracks the
//   expected FIFO contents, mode, trap registers and counters.
module tb_decode_ctrl;

  localparam int          DEPTH = 2;
  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ILL   = 32'hFFFF_FFFF;
  localparam int          M_INIT = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_TRAP = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] instr_in;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] dec_instr_out;
  logic        dec_nop;
  logic        dec_invalid;
  logic [59:0] dec_uop_in;
  logic [59:0] uop_out;
  logic [31:0] uop_pc;
  logic        uop_valid;
  logic        uop_ready;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_instr;
  logic [31:0] perf_uop_count;
  logic [31:0] perf_nop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_mode;
  logic [91:0] m_q[$];
  logic [31:0] m_uops;
  logic [31:0] m_nops;
  logic [31:0] m_tpc;
  logic [31:0] m_tinstr;

  // Expected outputs for the current cycle
  logic        exp_ready;
  logic        exp_valid;
  logic        exp_trap;
  logic [59:0] exp_uop;
  logic [31:0] exp_pc;

  decode_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_in(instr_in), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .dec_instr_out(dec_instr_out), .dec_nop(dec_nop),
    .dec_invalid(dec_invalid), .dec_uop_in(dec_uop_in),
    .uop_out(uop_out), .uop_pc(uop_pc), .uop_valid(uop_valid),
    .uop_ready(uop_ready), .trap(trap), .trap_pc(trap_pc),
    .trap_instr(trap_instr), .perf_uop_count(perf_uop_count),
    .perf_nop_count(perf_nop_count)
  );

  function automatic logic [59:0] uop_of(input logic [31:0] ins);
    return {~ins[27:0], ins};
  endfunction

  assign dec_nop     = (instr_in == NOP);
  assign dec_invalid = (instr_in == ILL);
  assign dec_uop_in  = uop_of(instr_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_q.delete();
    m_mode   = M_INIT;
    m_uops   = '0;
    m_nops   = '0;
    m_tpc    = '0;
    m_tinstr = '0;
  endtask

  // Apply inputs just after a falling edge and derive what the outputs
  // must show this cycle from the model.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ur, input logic fl);
    instr_valid = v;
    instr_in    = ins;
    instr_pc    = pc;
    uop_ready   = ur;
    flush       = fl;
    exp_ready   = (m_mode == M_RUN) && (m_q.size() < DEPTH) && !fl;
    exp_valid   = (m_q.size() != 0) && !fl;
    exp_trap    = (m_mode == M_TRAP);
    exp_uop     = (m_q.size() != 0) ? m_q[0][91:32] : '0;
    exp_pc      = (m_q.size() != 0) ? m_q[0][31:0] : '0;
    #1;
  endtask

  // Apply the transfer rules for the coming rising edge, then move to
  // the next falling edge.
  task automatic advance();
    logic acc;
    acc = instr_valid && exp_ready;
    if (flush) begin
      m_q.delete();
      m_mode = M_RUN;
    end else begin
      if (exp_valid && uop_ready) void'(m_q.pop_front());
      if (acc) begin
        if (instr_in == ILL) begin
          m_tpc    = instr_pc;
          m_tinstr = instr_in;
          m_mode   = M_TRAP;
        end else if (instr_in == NOP) begin
          m_nops = m_nops + 32'd1;
        end else begin
          m_q.push_back({uop_of(instr_in), instr_pc});
          m_uops = m_uops + 32'd1;
        end
      end
      if (m_mode == M_INIT) m_mode = M_RUN;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_q.size() != 0 && n < 20) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      advance();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b expected 0", instr_ready); end
    n_checks++; if (uop_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b expected 0", uop_valid); end
    n_checks++; if (uop_out !== 60'h0) begin n_fail++; $display("[TB] FAIL rst_uop: got %h expected 0", uop_out); end
    n_checks++; if (uop_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_uop_pc: got %h expected 0", uop_pc); end
    n_checks++; if (trap !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_trap: got %b expected 0", trap); end
    n_checks++; if (trap_pc !== 32'h0 || trap_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_trap_regs: got %h/%h expected 0/0", trap_pc, trap_instr); end
    n_checks++; if (perf_uop_count !== 32'h0 || perf_nop_count !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_counters: got %h/%h expected 0/0", perf_uop_count, perf_nop_count); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, ADDI, 32'h0, 1'b1, 1'b0);
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL startup_ready_low: got %b expected 0", instr_ready); end
    advance();
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    logic [31:0] want_pc;
    pc      = 32'h0;
    want_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ADDI, pc, 1'b1, 1'b0);
      n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, instr_ready); end
      n_checks++; if (uop_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", i, uop_valid, exp_valid); end
      if (exp_valid) begin
        n_checks++;
        if (uop_pc !== want_pc || uop_out !== uop_of(ADDI)) begin
          n_fail++; $display("[TB] FAIL stream_uop[%0d]: got pc %h uop %h expected pc %h uop %h", i, uop_pc, uop_out, want_pc, uop_of(ADDI));
        end
        want_pc = want_pc + 32'd4;
      end
      if (exp_ready) pc = pc + 32'd4;
      advance();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (perf_uop_count !== 32'd8) begin n_fail++; $display("[TB] FAIL stream_count: got %0d expected 8", perf_uop_count); end
    advance();
  endtask

  task automatic test_nop_drop();
    logic [31:0] prog[3];
    logic [31:0] seen[$];
    logic [31:0] u0;
    logic [31:0] n0;
    int k;
    int guard;
    prog  = '{ADDI, NOP, ADDI};
    drain();
    u0    = m_uops;
    n0    = m_nops;
    k     = 0;
    guard = 0;
    while ((k < 3 || m_q.size() != 0) && guard < 30) begin
      if (k < 3) drive(1'b1, prog[k], 32'h200 + 32'(4 * k), 1'b1, 1'b0);
      else       drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++; if (instr_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL nop_ready: got %b expected %b", instr_ready, exp_ready); end
      if (uop_valid) seen.push_back(uop_pc);
      if (k < 3 && exp_ready) k++;
      advance();
      guard++;
    end
    n_checks++; if (seen.size() != 2) begin n_fail++; $display("[TB] FAIL nop_uop_total: got %0d expected 2", seen.size()); end
    n_checks++; if (seen.size() < 2 || seen[0] !== 32'h200 || seen[1] !== 32'h208) begin n_fail++; $display("[TB] FAIL nop_pcs: got %p expected 200,208", seen); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (perf_nop_count !== n0 + 32'd1) begin n_fail++; $display("[TB] FAIL nop_count: got %0d expected %0d", perf_nop_count, n0 + 32'd1); end
    n_checks++; if (perf_uop_count !== u0 + 32'd2) begin n_fail++; $display("[TB] FAIL nop_uop_count: got %0d expected %0d", perf_uop_count, u0 + 32'd2); end
    advance();
  endtask

  task automatic test_backpressure();
    logic [31:0] pc;
    logic [31:0] seen[$];
    int acc_dut;
    drain();
    pc      = 32'h300;
    acc_dut = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDI + 32'(i << 20), pc, 1'b0, 1'b0);
      if (instr_ready === 1'b1) acc_dut++;
      if (exp_ready) pc = pc + 32'd4;
      advance();
    end
    n_checks++; if (acc_dut != DEPTH) begin n_fail++; $display("[TB] FAIL bp_accepted: got %0d expected %0d", acc_dut, DEPTH); end
    drive(1'b1, ADDI, pc, 1'b0, 1'b0);
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_full: got %b expected 0", instr_ready); end
    n_checks++; if (uop_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid_held: got %b expected 1", uop_valid); end
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      if (uop_valid === 1'b1) begin
        seen.push_back(uop_pc);
        n_checks++; if (uop_out !== exp_uop) begin n_fail++; $display("[TB] FAIL bp_uop: got %h expected %h", uop_out, exp_uop); end
      end
      advance();
    end
    n_checks++; if (seen.size() != 2 || seen[0] !== 32'h300 || seen[1] !== 32'h304) begin n_fail++; $display("[TB] FAIL bp_order: got %p expected 300,304", seen); end
  endtask

  task automatic test_illegal();
    logic [31:0] seen[$];
    drain();
    drive(1'b1, ADDI, 32'hFC, 1'b0, 1'b0);
    advance();
    drive(1'b1, ILL, 32'h100, 1'b0, 1'b0);
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_accept: got %b expected 1", instr_ready); end
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (trap !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_trap: got %b expected 1", trap); end
    n_checks++; if (trap_pc !== 32'h100) begin n_fail++; $display("[TB] FAIL ill_trap_pc: got %h expected 100", trap_pc); end
    n_checks++; if (trap_instr !== ILL) begin n_fail++; $display("[TB] FAIL ill_trap_instr: got %h expected ffffffff", trap_instr); end
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDI, 32'h104, 1'b1, 1'b0);
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_ready_low[%0d]: got %b expected 0", i, instr_ready); end
      n_checks++; if (trap !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_trap_hold[%0d]: got %b expected 1", i, trap); end
      if (uop_valid === 1'b1) seen.push_back(uop_pc);
      advance();
    end
    n_checks++; if (seen.size() != 1 || seen[0] !== 32'hFC) begin n_fail++; $display("[TB] FAIL ill_drain: got %p expected fc", seen); end
  endtask

  task automatic test_flush();
    logic [31:0] u0;
    logic [31:0] n0;
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_ready_in_flush: got %b expected 0", instr_ready); end
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (trap !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_exit_trap: got trap %b ready %b expected 0/1", trap, instr_ready); end
    advance();
    drive(1'b1, ADDI, 32'h400, 1'b0, 1'b0);
    advance();
    drive(1'b1, ILL, 32'h404, 1'b0, 1'b0);
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_checks++; if (trap !== 1'b1 || uop_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_cycle: got trap %b valid %b expected 1/0", trap, uop_valid); end
    u0 = m_uops;
    n0 = m_nops;
    advance();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (uop_valid !== 1'b0 || trap !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_trap_after: got valid %b trap %b ready %b expected 0/0/1", uop_valid, trap, instr_ready); end
    n_checks++; if (perf_uop_count !== u0 || perf_nop_count !== n0) begin n_fail++; $display("[TB] FAIL fl_counters: got %0d/%0d expected %0d/%0d", perf_uop_count, perf_nop_count, u0, n0); end
    advance();
    drive(1'b1, ADDI, 32'h500, 1'b0, 1'b0);
    advance();
    drive(1'b1, ADDI, 32'h504, 1'b0, 1'b0);
    advance();
    drive(1'b1, ADDI, 32'h508, 1'b0, 1'b0);
    n_checks++; if (instr_ready !== 1'b0 || uop_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_full: got ready %b valid %b expected 0/1", instr_ready, uop_valid); end
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    advance();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (uop_valid !== 1'b0 || trap !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_full_after: got valid %b trap %b ready %b expected 0/0/1", uop_valid, trap, instr_ready); end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] ins;
    logic        v;
    logic        ur;
    logic        fl;
    int          r;
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      ins = (r < 15) ? NOP : (r < 20) ? ILL : $urandom();
      v   = ($urandom_range(0, 3) != 0);
      ur  = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 29) == 0) || (m_mode == M_TRAP && $urandom_range(0, 7) == 0);
      drive(v, ins, pc, ur, fl);
      n_checks++; if (instr_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", i, instr_ready, exp_ready); end
      n_checks++; if (uop_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, uop_valid, exp_valid); end
      if (exp_valid) begin
        n_checks++; if (uop_out !== exp_uop || uop_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL rnd_head[%0d]: got %h@%h expected %h@%h", i, uop_out, uop_pc, exp_uop, exp_pc); end
      end
      n_checks++; if (trap !== exp_trap) begin n_fail++; $display("[TB] FAIL rnd_trap[%0d]: got %b expected %b", i, trap, exp_trap); end
      if (exp_trap) begin
        n_checks++; if (trap_pc !== m_tpc || trap_instr !== m_tinstr) begin n_fail++; $display("[TB] FAIL rnd_trap_regs[%0d]: got %h/%h expected %h/%h", i, trap_pc, trap_instr, m_tpc, m_tinstr); end
      end
      n_checks++; if (perf_uop_count !== m_uops || perf_nop_count !== m_nops) begin n_fail++; $display("[TB] FAIL rnd_counters[%0d]: got %0d/%0d expected %0d/%0d", i, perf_uop_count, perf_nop_count, m_uops, m_nops); end
      n_checks++; if (dec_instr_out !== ins) begin n_fail++; $display("[TB] FAIL rnd_dec_instr[%0d]: got %h expected %h", i, dec_instr_out, ins); end
      if (v && exp_ready) pc = pc + 32'd4;
      advance();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    advance();
  endtask

  task automatic test_counter_wrap();
    drain();
    force dut.uop_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.uop_cnt_q;
    m_uops = 32'hFFFF_FFFF;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (perf_uop_count !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL wrap_preset: got %h expected ffffffff", perf_uop_count); end
    advance();
    drive(1'b1, ADDI, 32'h600, 1'b1, 1'b0);
    advance();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (perf_uop_count !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_zero: got %h expected 0", perf_uop_count); end
    advance();
    drain();
  endtask

  task automatic test_async_reset();
    drive(1'b1, ADDI, 32'h700, 1'b0, 1'b0);
    advance();
    drive(1'b1, ILL, 32'h704, 1'b0, 1'b0);
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (instr_ready !== 1'b0 || uop_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_handshake: got ready %b valid %b expected 0/0", instr_ready, uop_valid); end
    n_checks++; if (uop_out !== 60'h0 || uop_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL ar_head: got %h@%h expected 0@0", uop_out, uop_pc); end
    n_checks++; if (trap !== 1'b0 || trap_pc !== 32'h0 || trap_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL ar_trap: got %b %h %h expected 0 0 0", trap, trap_pc, trap_instr); end
    n_checks++; if (perf_uop_count !== 32'h0 || perf_nop_count !== 32'h0) begin n_fail++; $display("[TB] FAIL ar_counters: got %h/%h expected 0/0", perf_uop_count, perf_nop_count); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, ADDI, 32'h0, 1'b1, 1'b0);
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_init_ready: got %b expected 0", instr_ready); end
    advance();
    drive(1'b1, ADDI, 32'h0, 1'b1, 1'b0);
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_run_ready: got %b expected 1", instr_ready); end
    advance();
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    instr_in    = '0;
    instr_pc    = '0;
    instr_valid = 1'b0;
    uop_ready   = 1'b0;
    test_reset();
    test_stream();
    test_nop_drop();
    test_backpressure();
    test_illegal();
    test_flush();
    test_random();
    test_counter_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
